state_flag_bank: RTL and testbench

Parametrised bank of sticky state flags that generalises the single-bit "set once, hold until cleared" state registers used by the control FSMs. Each of `N_CH` channels latches an event and counts occurrences in a saturating counter. The bank also records which channel fired first and reports any-set and all-set summaries. It sits between the event sources (game/control logic) and the main controller, which polls and clears flags.

---
 rtl/state_flag_bank.sv | 86 ++++++++
 tb/tb_state_flag_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/state_flag_bank.sv
// Bank of sticky event flags with saturating occurrence counters,
// first-event capture and any/all summaries for controller polling.
module state_flag_bank #(
  parameter int N_CH = 4,
  parameter int CNT_W = 4,
  parameter int EDGE_MODE = 1,
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CH-1:0]         set_in,
  input  logic [N_CH-1:0]         clr,
  input  logic                    clr_all,
  output logic [N_CH-1:0]         flags,
  output logic [N_CH*CNT_W-1:0]   count,
  output logic                    any_set,
  output logic                    all_set,
  output logic                    first_vld,
  output logic [IDX_W-1:0]        first_idx
);

  logic [N_CH-1:0]  set_q;
  logic [N_CH-1:0]  ev;
  logic [N_CH-1:0]  acc;
  logic [IDX_W-1:0] lo_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      set_q <= '0;
    end else begin
      set_q <= set_in;
    end
  end

  assign ev = (EDGE_MODE != 0) ? (set_in & ~set_q) : set_in;

  // A clear on the same channel discards that cycle's event entirely.
  assign acc = clr_all ? '0 : (ev & ~clr);

  always_comb begin
    lo_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (acc[i]) begin
        lo_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags     <= '0;
      first_vld <= 1'b0;
      first_idx <= '0;
    end else if (clr_all) begin
      flags     <= '0;
      first_vld <= 1'b0;
      first_idx <= '0;
    end else begin
      flags <= (flags & ~clr) | acc;
      if (!first_vld && (|acc)) begin
        first_vld <= 1'b1;
        first_idx <= lo_idx;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (clr_all || clr[g]) begin
        cnt <= '0;
      end else if (acc[g] && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign count[g*CNT_W +: CNT_W] = cnt;
  end

  assign any_set = |flags;
  assign all_set = &flags;

endmodule

// File: tb/tb_state_flag_bank.sv
// Scoreboard bench: edge-mode and level-mode banks share stimulus;
// expectations are queued by stimulus and checked by a monitor.
module tb_state_flag_bank;

  logic       clk;
  logic       reset_n;
  logic [3:0] set_in;
  logic [3:0] clr;
  logic       clr_all;

  logic [3:0]  fl_e, fl_l;
  logic [15:0] cn_e, cn_l;
  logic        any_e, any_l, all_e, all_l, fv_e, fv_l;
  logic [1:0]  fi_e, fi_l;

  state_flag_bank #(.N_CH(4), .CNT_W(4), .EDGE_MODE(1)) u_edge (
    .clk(clk), .reset_n(reset_n), .set_in(set_in), .clr(clr),
    .clr_all(clr_all), .flags(fl_e), .count(cn_e), .any_set(any_e),
    .all_set(all_e), .first_vld(fv_e), .first_idx(fi_e)
  );

  state_flag_bank #(.N_CH(4), .CNT_W(4), .EDGE_MODE(0)) u_lvl (
    .clk(clk), .reset_n(reset_n), .set_in(set_in), .clr(clr),
    .clr_all(clr_all), .flags(fl_l), .count(cn_l), .any_set(any_l),
    .all_set(all_l), .first_vld(fv_l), .first_idx(fi_l)
  );

  typedef struct {
    string name;
    int    d;
    int    sel;
    int    ch;
    int    val;
  } exp_t;

  exp_t q[$];
  int   ncmp = 0;
  int   nmis = 0;
  event chk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int get(int d, int sel, int ch);
    case (sel)
      0: return d != 0 ? int'(fl_l) : int'(fl_e);
      1: return d != 0 ? int'(cn_l[ch*4 +: 4]) : int'(cn_e[ch*4 +: 4]);
      2: return d != 0 ? int'(any_l) : int'(any_e);
      3: return d != 0 ? int'(all_l) : int'(all_e);
      4: return d != 0 ? int'(fv_l) : int'(fv_e);
      default: return d != 0 ? int'(fi_l) : int'(fi_e);
    endcase
  endfunction

  task automatic ex(string n, int d, int sel, int ch, int v);
    q.push_back('{n, d, sel, ch, v});
  endtask

  task automatic zeros(string n, int d);
    for (int s = 0; s < 6; s++) begin
      if (s != 1) ex(n, d, s, 0, 0);
    end
    for (int c = 0; c < 4; c++) ex(n, d, 1, c, 0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin : mon
    exp_t e;
    int   a;
    forever begin
      @(negedge clk or chk);
      while (q.size() > 0) begin
        e = q.pop_front();
        a = get(e.d, e.sel, e.ch);
        ncmp++;
        if (a !== e.val) begin
          nmis++;
          $display("FAIL %s dut%0d sel%0d ch%0d: got %0d want %0d",
                   e.name, e.d, e.sel, e.ch, a, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    set_in  = '0;
    clr     = '0;
    clr_all = 1'b0;
    reset_n = 1'b0;
    #3;
    zeros("reset", 0);
    zeros("reset", 1);
    ->chk;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    tick;

    // edge vs level on channel 0: high 5, low 1, high 3
    set_in = 4'b0001;
    tick;
    ex("a_fvld", 0, 4, 0, 1);
    ex("a_fidx", 0, 5, 0, 0);
    repeat (4) tick;
    set_in = 4'b0000;
    tick;
    set_in = 4'b0001;
    repeat (3) tick;
    set_in = 4'b0000;
    ex("a_cnt_edge", 0, 1, 0, 2);
    ex("a_cnt_lvl", 1, 1, 0, 8);
    ex("a_flags", 0, 0, 0, 1);
    clr_all = 1'b1;
    tick;
    clr_all = 1'b0;
    ex("a_clr_fl", 1, 0, 0, 0);
    ex("a_clr_fv", 0, 4, 0, 0);
    ex("a_clr_cnt", 1, 1, 0, 0);

    // saturation on channel 1
    set_in = 4'b0010;
    repeat (15) tick;
    ex("b_sat15", 1, 1, 1, 15);
    repeat (5) tick;
    ex("b_sat_hold", 1, 1, 1, 15);
    ex("b_sat_fl", 1, 0, 0, 2);
    ex("b_edge_one", 0, 1, 1, 1);
    set_in  = 4'b0000;
    clr_all = 1'b1;
    tick;
    clr_all = 1'b0;

    // simultaneous first events
    set_in = 4'b1010;
    tick;
    ex("c_fidx", 0, 5, 0, 1);
    ex("c_fidx_l", 1, 5, 0, 1);
    ex("c_fvld", 0, 4, 0, 1);
    ex("c_flags", 0, 0, 0, 10);
    set_in = 4'b0000;
    tick;
    set_in = 4'b0001;
    tick;
    ex("c_fidx_hold", 0, 5, 0, 1);
    ex("c_flags2", 0, 0, 0, 11);
    set_in = 4'b0000;
    clr    = 4'b0010;
    tick;
    ex("c_clr_fvld", 0, 4, 0, 1);
    ex("c_clr_fl", 0, 0, 0, 9);
    clr     = 4'b0000;
    clr_all = 1'b1;
    tick;
    clr_all = 1'b0;
    ex("c_all_fv", 0, 4, 0, 0);
    ex("c_all_fv_l", 1, 4, 0, 0);
    ex("c_all_fl", 0, 0, 0, 0);

    // clear priority
    set_in = 4'b0100;
    clr    = 4'b0100;
    tick;
    ex("d_fl", 0, 0, 0, 0);
    ex("d_cnt", 0, 1, 2, 0);
    ex("d_cnt_l", 1, 1, 2, 0);
    ex("d_fvld", 0, 4, 0, 0);
    set_in = 4'b0000;
    clr    = 4'b0000;
    tick;
    set_in  = 4'b1111;
    clr_all = 1'b1;
    tick;
    zeros("d_clrall", 0);
    zeros("d_clrall", 1);
    set_in  = 4'b0000;
    clr_all = 1'b0;
    tick;

    // summaries
    set_in = 4'b0001;
    tick;
    ex("e_any1", 0, 2, 0, 1);
    ex("e_all1", 0, 3, 0, 0);
    set_in = 4'b0010;
    tick;
    ex("e_all2", 0, 3, 0, 0);
    set_in = 4'b0100;
    tick;
    ex("e_all3", 0, 3, 0, 0);
    set_in = 4'b1000;
    tick;
    ex("e_all4", 0, 3, 0, 1);
    ex("e_all4_l", 1, 3, 0, 1);
    ex("e_fl4", 0, 0, 0, 15);
    set_in = 4'b0000;
    clr    = 4'b0001;
    tick;
    clr = 4'b0000;
    ex("e_clr_all", 0, 3, 0, 0);
    ex("e_clr_any", 0, 2, 0, 1);
    ex("e_clr_fl", 0, 0, 0, 14);

    // asynchronous reset between edges, release with channel 2 high
    set_in = 4'b0101;
    tick;
    #2;
    reset_n = 1'b0;
    #1;
    zeros("f_async", 0);
    zeros("f_async", 1);
    ->chk;
    #1;
    set_in = 4'b0100;
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    ex("f_fl", 0, 0, 0, 4);
    ex("f_cnt", 0, 1, 2, 1);
    ex("f_fidx", 0, 5, 0, 2);
    ex("f_fvld", 0, 4, 0, 1);
    ex("f_fl_l", 1, 0, 0, 4);
    ex("f_cnt_l", 1, 1, 2, 1);
    set_in = 4'b0000;

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
